// File: rtl/zorro_master_cycle.sv
// Zorro III bus-master cycle sequencer for the A4092 DMA path.
// Runs one longword read/write per local request, with arbitration hold.
//
// Ports:
//   CLK, RESET      bus clock, synchronous active-high reset
//   REQ..REQ_BE     local request (held until ACK), direction, address,
//                   write data, byte enables ([3] = D31:24)
//   ACK, ERR        one-cycle completion pulse, error flag with it
//   RDATA           read data, valid with ACK, held until next ACK
//   MASTER          ownership request to the arbiter
//   BUS_OWNED       ownership grant (already synchronous)
//   HOLD            keep the bus between back-to-back requests
//   Z_*             Zorro III strobes, AD bus and async DTACK/BERR
module zorro_master_cycle #(
    parameter int ADDR_SETUP = 1,
    parameter int DS_DELAY   = 1,
    parameter int TIMEOUT    = 64,
    parameter int TO_W       = 7
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [3:0]  REQ_BE,
    output logic        ACK,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic        MASTER,
    input  logic        BUS_OWNED,
    input  logic        HOLD,
    output logic [31:0] Z_AD_OUT,
    output logic        Z_AD_OE,
    output logic        Z_FCS_n,
    output logic [3:0]  Z_DS_n,
    output logic        Z_READ,
    output logic        Z_DOE,
    input  logic        Z_DTACK_n,
    input  logic        Z_BERR_n,
    input  logic [31:0] Z_AD_IN
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OWN_WAIT,
        S_ADDR,
        S_STROBE,
        S_WAIT,
        S_TERM
    } state_t;

    state_t state_q, state_d;

    logic [1:0]      ph_q;
    logic [TO_W-1:0] to_q;
    logic            dtack_m, dtack_s;
    logic            berr_m, berr_s;
    logic            lost_q;

    logic            rw_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;

    logic            err_d;
    logic            cap_d;
    logic            load_d;
    logic            to_hit;
    logic            on_bus;

    logic            rw_n;
    logic [31:0]     addr_n;
    logic [31:0]     wdata_n;
    logic [3:0]      be_n;

    logic [31:0]     ad_out_d;
    logic            ad_oe_d;
    logic            fcs_n_d;
    logic [3:0]      ds_n_d;
    logic            read_d;
    logic            doe_d;

    assign to_hit = (to_q == TO_W'(TIMEOUT - 1));
    assign on_bus = (state_q == S_ADDR) || (state_q == S_STROBE) ||
                    (state_q == S_WAIT) || (state_q == S_TERM);

    // Next-state logic. BERR outranks DTACK, and a real termination
    // outranks the timeout when both land on the same edge.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        cap_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (REQ) state_d = BUS_OWNED ? S_ADDR : S_OWN_WAIT;
            end
            S_OWN_WAIT: begin
                if (BUS_OWNED) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (ph_q == 2'(ADDR_SETUP - 1)) state_d = S_STROBE;
            end
            S_STROBE: begin
                if (!berr_s || to_hit) begin
                    state_d = S_TERM;
                    err_d   = 1'b1;
                end else if (ph_q == 2'(DS_DELAY - 1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!berr_s) begin
                    state_d = S_TERM;
                    err_d   = 1'b1;
                end else if (!dtack_s) begin
                    state_d = S_TERM;
                    cap_d   = rw_q;
                end else if (to_hit) begin
                    state_d = S_TERM;
                    err_d   = 1'b1;
                end
            end
            S_TERM: begin
                if (HOLD && REQ && BUS_OWNED && !lost_q) state_d = S_ADDR;
                else                                     state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured when a cycle is accepted from IDLE or
    // chained straight out of TERM; outputs decode the post-edge values.
    assign load_d  = ((state_q == S_IDLE) && REQ) ||
                     ((state_q == S_TERM) && (state_d == S_ADDR));
    assign rw_n    = load_d ? REQ_RW    : rw_q;
    assign addr_n  = load_d ? REQ_ADDR  : addr_q;
    assign wdata_n = load_d ? REQ_WDATA : wdata_q;
    assign be_n    = load_d ? REQ_BE    : be_q;

    // Bus outputs are registered from the next state so they never glitch.
    always_comb begin
        ad_out_d = '0;
        ad_oe_d  = 1'b0;
        fcs_n_d  = 1'b1;
        ds_n_d   = 4'hF;
        read_d   = 1'b1;
        doe_d    = 1'b0;
        unique case (state_d)
            S_ADDR: begin
                ad_out_d = addr_n & 32'hFFFF_FFFC;
                ad_oe_d  = 1'b1;
                read_d   = rw_n;
            end
            S_STROBE: begin
                ad_out_d = addr_n & 32'hFFFF_FFFC;
                ad_oe_d  = 1'b1;
                fcs_n_d  = 1'b0;
                read_d   = rw_n;
            end
            S_WAIT: begin
                fcs_n_d = 1'b0;
                ds_n_d  = ~be_n;
                read_d  = rw_n;
                doe_d   = 1'b1;
                if (rw_n) begin
                    ad_out_d = addr_n & 32'hFFFF_FFFC;
                    ad_oe_d  = 1'b0;
                end else begin
                    ad_out_d = wdata_n;
                    ad_oe_d  = 1'b1;
                end
            end
            S_TERM: begin
                read_d = rw_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            to_q     <= '0;
            dtack_m  <= 1'b1;
            dtack_s  <= 1'b1;
            berr_m   <= 1'b1;
            berr_s   <= 1'b1;
            lost_q   <= 1'b0;
            rw_q     <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            ACK      <= 1'b0;
            ERR      <= 1'b0;
            RDATA    <= '0;
            MASTER   <= 1'b0;
            Z_AD_OUT <= '0;
            Z_AD_OE  <= 1'b0;
            Z_FCS_n  <= 1'b1;
            Z_DS_n   <= 4'hF;
            Z_READ   <= 1'b1;
            Z_DOE    <= 1'b0;
        end else begin
            state_q <= state_d;
            dtack_m <= Z_DTACK_n;
            dtack_s <= dtack_m;
            berr_m  <= Z_BERR_n;
            berr_s  <= berr_m;

            // Phase counter restarts on every state change.
            if (state_d != state_q) ph_q <= '0;
            else                    ph_q <= ph_q + 2'd1;

            // Timeout runs from FCS assertion for as long as FCS is low.
            if ((state_d == S_STROBE) && (state_q != S_STROBE))
                to_q <= '0;
            else if ((state_q == S_STROBE) || (state_q == S_WAIT))
                to_q <= to_q + TO_W'(1);

            // Losing the grant mid-cycle forbids chaining from TERM.
            if (state_d == S_IDLE)         lost_q <= 1'b0;
            else if (on_bus && !BUS_OWNED) lost_q <= 1'b1;

            rw_q    <= rw_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            be_q    <= be_n;

            if (cap_d) RDATA <= Z_AD_IN;

            ACK      <= (state_d == S_TERM);
            ERR      <= (state_d == S_TERM) && err_d;
            MASTER   <= (state_d != S_IDLE);
            Z_AD_OUT <= ad_out_d;
            Z_AD_OE  <= ad_oe_d;
            Z_FCS_n  <= fcs_n_d;
            Z_DS_n   <= ds_n_d;
            Z_READ   <= read_d;
            Z_DOE    <= doe_d;
        end
    end

endmodule

// File: tb/tb_zorro_master_cycle.sv
// Testbench for zorro_master_cycle: directed scenarios plus randomized
// transactions checked against a latency/result model of the bus rules.
module tb_zorro_master_cycle;

    localparam int ADDR_SETUP = 1;
    localparam int DS_DELAY   = 1;
    localparam int TIMEOUT    = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ;
    logic        REQ_RW;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic [3:0]  REQ_BE;
    logic        ACK;
    logic        ERR;
    logic [31:0] RDATA;
    logic        MASTER;
    logic        BUS_OWNED;
    logic        HOLD;
    logic [31:0] Z_AD_OUT;
    logic        Z_AD_OE;
    logic        Z_FCS_n;
    logic [3:0]  Z_DS_n;
    logic        Z_READ;
    logic        Z_DOE;
    logic        Z_DTACK_n;
    logic        Z_BERR_n;
    logic [31:0] Z_AD_IN;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata;

    always #5 CLK = ~CLK;

    zorro_master_cycle #(
        .ADDR_SETUP(ADDR_SETUP),
        .DS_DELAY  (DS_DELAY),
        .TIMEOUT   (TIMEOUT),
        .TO_W      (7)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ      (REQ),
        .REQ_RW   (REQ_RW),
        .REQ_ADDR (REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .REQ_BE   (REQ_BE),
        .ACK      (ACK),
        .ERR      (ERR),
        .RDATA    (RDATA),
        .MASTER   (MASTER),
        .BUS_OWNED(BUS_OWNED),
        .HOLD     (HOLD),
        .Z_AD_OUT (Z_AD_OUT),
        .Z_AD_OE  (Z_AD_OE),
        .Z_FCS_n  (Z_FCS_n),
        .Z_DS_n   (Z_DS_n),
        .Z_READ   (Z_READ),
        .Z_DOE    (Z_DOE),
        .Z_DTACK_n(Z_DTACK_n),
        .Z_BERR_n (Z_BERR_n),
        .Z_AD_IN  (Z_AD_IN)
    );

    // Reference model: REQ-to-ACK clock count from the bus rules.
    // Response path = DS delay, target delay d, 2 sync FFs, WAIT decision.
    // mode: 0 DTACK, 1 BERR, 2 both, 3 silent target.
    function automatic int exp_latency(int w, int mode, int d);
        int resp;
        resp = DS_DELAY + d + 3;
        if (mode == 3 || resp > TIMEOUT) resp = TIMEOUT;
        return 1 + w + ADDR_SETUP + resp;
    endfunction

    function automatic logic exp_error(int mode, int d);
        return (mode != 0) || (DS_DELAY + d + 3 > TIMEOUT);
    endfunction

    // Requester + arbiter + target driver. Observes at the falling edge.
    task automatic do_txn(
        input  logic        rw,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [3:0]  be,
        input  logic [31:0] rdat,
        input  int          w,
        input  int          mode,
        input  int          d,
        input  bit          keep,
        input  int          drop_at,
        output int          lat,
        output logic        err,
        output logic [31:0] a_seen,
        output logic [31:0] wd_seen,
        output logic [3:0]  ds_seen,
        output logic        rd_seen,
        output bit          m_low
    );
        int ds_cyc;
        bit ds_flag;
        bit a_flag;
        REQ       = 1'b1;
        REQ_RW    = rw;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        REQ_BE    = be;
        Z_AD_IN   = rdat;
        if (w == 0) BUS_OWNED = 1'b1;
        else        BUS_OWNED = 1'b0;
        lat     = 0;
        err     = 1'b0;
        a_seen  = '0;
        wd_seen = '0;
        ds_seen = 4'hF;
        rd_seen = 1'b0;
        m_low   = 1'b0;
        ds_cyc  = 0;
        ds_flag = 1'b0;
        a_flag  = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (w > 0 && c == w) BUS_OWNED = 1'b1;
            if (c == drop_at)    BUS_OWNED = 1'b0;
            if (!MASTER) m_low = 1'b1;
            if (!a_flag && Z_AD_OE && Z_FCS_n) begin
                a_flag  = 1'b1;
                a_seen  = Z_AD_OUT;
                rd_seen = Z_READ;
            end
            if (!ds_flag && Z_DS_n != 4'hF) begin
                ds_flag = 1'b1;
                ds_cyc  = c;
                ds_seen = Z_DS_n;
                wd_seen = Z_AD_OUT;
            end
            if (ds_flag && c == ds_cyc + d) begin
                if (mode == 0 || mode == 2) Z_DTACK_n = 1'b0;
                if (mode == 1 || mode == 2) Z_BERR_n  = 1'b0;
            end
            if (ACK) begin
                lat       = c;
                err       = ERR;
                Z_DTACK_n = 1'b1;
                Z_BERR_n  = 1'b1;
                if (!keep) REQ = 1'b0;
                break;
            end
        end
        if (lat == 0) begin
            Z_DTACK_n = 1'b1;
            Z_BERR_n  = 1'b1;
            REQ       = 1'b0;
        end
    endtask

    task automatic test_reset();
        RESET     = 1'b1;
        REQ       = 1'b0;
        REQ_RW    = 1'b1;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        REQ_BE    = '0;
        BUS_OWNED = 1'b0;
        HOLD      = 1'b0;
        Z_DTACK_n = 1'b1;
        Z_BERR_n  = 1'b1;
        Z_AD_IN   = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({MASTER, ACK, ERR, Z_AD_OE, Z_FCS_n, Z_DS_n, Z_READ, Z_DOE}
            !== 11'b000_0_1_1111_1_0) begin
            errors++;
            $display("FAIL reset_ctl: got %b exp %b",
                {MASTER, ACK, ERR, Z_AD_OE, Z_FCS_n, Z_DS_n, Z_READ, Z_DOE},
                11'b000_0_1_1111_1_0);
        end
        checks++;
        if (RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h exp 0", RDATA);
        end
        checks++;
        if (Z_AD_OUT !== 32'h0) begin
            errors++;
            $display("FAIL reset_ad_out: got %h exp 0", Z_AD_OUT);
        end
        RESET     = 1'b0;
        exp_rdata = '0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_read_basic();
        int lat; logic err, rd; logic [31:0] a, wd; logic [3:0] ds; bit ml;
        do_txn(1'b1, 32'h1000_0008, 32'h0, 4'hF, 32'hDEAD_BEEF,
               0, 0, 0, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        exp_rdata = 32'hDEAD_BEEF;
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL read_latency: got %0d exp 6", lat);
        end
        checks++;
        if (err !== 1'b0 || RDATA !== exp_rdata) begin
            errors++;
            $display("FAIL read_data: err %b rdata %h exp err 0 rdata %h",
                     err, RDATA, exp_rdata);
        end
        checks++;
        if (a !== 32'h1000_0008 || rd !== 1'b1 || ds !== 4'h0) begin
            errors++;
            $display("FAIL read_bus: addr %h read %b ds %b exp 10000008 1 0000",
                     a, rd, ds);
        end
        @(negedge CLK);
        checks++;
        if (ACK !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: ack %b exp 0 one cycle later", ACK);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_write();
        int lat; logic err, rd; logic [31:0] a, wd; logic [3:0] ds; bit ml;
        do_txn(1'b0, 32'h4000_1234, 32'h0000_A55A, 4'b0011, 32'h5555_5555,
               0, 0, 0, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        checks++;
        if (a !== 32'h4000_1234 || rd !== 1'b0) begin
            errors++;
            $display("FAIL write_addr: addr %h read %b exp 40001234 0", a, rd);
        end
        checks++;
        if (wd !== 32'h0000_A55A || ds !== 4'b1100) begin
            errors++;
            $display("FAIL write_data: data %h ds %b exp 0000a55a 1100", wd, ds);
        end
        checks++;
        if (lat != 6 || err !== 1'b0 || RDATA !== exp_rdata) begin
            errors++;
            $display("FAIL write_done: lat %0d err %b rdata %h exp 6 0 %h",
                     lat, err, RDATA, exp_rdata);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_timeout();
        int lat; logic err, rd; logic [31:0] a, wd; logic [3:0] ds; bit ml;
        do_txn(1'b1, 32'h2000_0000, 32'h0, 4'hF, 32'h0BAD_F00D,
               0, 3, 0, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        checks++;
        if (lat != exp_latency(0, 3, 0) || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: lat %0d err %b exp %0d 1",
                     lat, err, exp_latency(0, 3, 0));
        end
        checks++;
        if (Z_FCS_n !== 1'b1 || RDATA !== exp_rdata) begin
            errors++;
            $display("FAIL timeout_term: fcs_n %b rdata %h exp 1 %h",
                     Z_FCS_n, RDATA, exp_rdata);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_berr_dtack();
        int lat; logic err, rd; logic [31:0] a, wd; logic [3:0] ds; bit ml;
        do_txn(1'b1, 32'h3000_0010, 32'h0, 4'hF, 32'h1234_5678,
               0, 2, 1, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        checks++;
        if (lat != 7 || err !== 1'b1 || RDATA !== exp_rdata) begin
            errors++;
            $display("FAIL berr_dtack: lat %0d err %b rdata %h exp 7 1 %h",
                     lat, err, RDATA, exp_rdata);
        end
        repeat (3) @(negedge CLK);
        do_txn(1'b0, 32'h3000_0020, 32'hCAFE_0001, 4'b1000, 32'h0,
               0, 1, 0, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        checks++;
        if (lat != 6 || err !== 1'b1 || ds !== 4'b0111) begin
            errors++;
            $display("FAIL berr_write: lat %0d err %b ds %b exp 6 1 0111",
                     lat, err, ds);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int lat; logic err, rd; logic [31:0] a, wd; logic [3:0] ds; bit ml;
        HOLD = 1'b1;
        do_txn(1'b1, 32'h5000_0000, 32'h0, 4'hF, 32'h1111_2222,
               0, 0, 0, 1'b1, 0, lat, err, a, wd, ds, rd, ml);
        do_txn(1'b1, 32'h5000_0004, 32'h0, 4'hF, 32'h3333_4444,
               0, 0, 0, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        exp_rdata = 32'h3333_4444;
        checks++;
        if (lat != 6 || ml || RDATA !== exp_rdata || a !== 32'h5000_0004) begin
            errors++;
            $display("FAIL hold_chain: lat %0d mlow %0d rdata %h addr %h exp 6 0 %h 50000004",
                     lat, ml, RDATA, a, exp_rdata);
        end
        @(negedge CLK);
        checks++;
        if (MASTER !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: master %b exp 0", MASTER);
        end
        repeat (2) @(negedge CLK);
        HOLD = 1'b0;
        do_txn(1'b1, 32'h6000_0000, 32'h0, 4'hF, 32'h5555_6666,
               0, 0, 0, 1'b1, 0, lat, err, a, wd, ds, rd, ml);
        do_txn(1'b1, 32'h6000_0004, 32'h0, 4'hF, 32'h7777_8888,
               0, 0, 0, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        exp_rdata = 32'h7777_8888;
        checks++;
        if (lat != 7 || !ml || RDATA !== exp_rdata) begin
            errors++;
            $display("FAIL nohold: lat %0d mlow %0d rdata %h exp 7 1 %h",
                     lat, ml, RDATA, exp_rdata);
        end
        repeat (2) @(negedge CLK);
        // Grant withdrawn mid-cycle: cycle finishes, then full re-arbitration.
        HOLD = 1'b1;
        do_txn(1'b1, 32'h7000_0000, 32'h0, 4'hF, 32'h9999_AAAA,
               0, 0, 0, 1'b1, 3, lat, err, a, wd, ds, rd, ml);
        exp_rdata = 32'h9999_AAAA;
        checks++;
        if (lat != 6 || err !== 1'b0 || RDATA !== exp_rdata) begin
            errors++;
            $display("FAIL own_drop_first: lat %0d err %b rdata %h exp 6 0 %h",
                     lat, err, RDATA, exp_rdata);
        end
        do_txn(1'b1, 32'h7000_0004, 32'h0, 4'hF, 32'hBBBB_CCCC,
               2, 0, 0, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        exp_rdata = 32'hBBBB_CCCC;
        checks++;
        if (lat != 8 || !ml || RDATA !== exp_rdata) begin
            errors++;
            $display("FAIL own_drop_next: lat %0d mlow %0d rdata %h exp 8 1 %h",
                     lat, ml, RDATA, exp_rdata);
        end
        HOLD = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int lat; logic err, rd; logic [31:0] a, wd; logic [3:0] ds; bit ml;
        bit in_wait;
        bit ack_seen;
        REQ       = 1'b1;
        REQ_RW    = 1'b1;
        REQ_ADDR  = 32'h8000_0000;
        REQ_BE    = 4'hF;
        BUS_OWNED = 1'b1;
        in_wait   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (Z_DS_n != 4'hF) begin
                in_wait = 1'b1;
                break;
            end
        end
        checks++;
        if (!in_wait) begin
            errors++;
            $display("FAIL reset_mid_reach: ds_n %b never asserted", Z_DS_n);
        end
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({Z_FCS_n, Z_DS_n, MASTER, ACK} !== 7'b1_1111_0_0) begin
            errors++;
            $display("FAIL reset_mid: fcs ds master ack %b exp 1111100",
                     {Z_FCS_n, Z_DS_n, MASTER, ACK});
        end
        REQ       = 1'b0;
        RESET     = 1'b0;
        exp_rdata = '0;
        ack_seen  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (ACK) ack_seen = 1'b1;
        end
        checks++;
        if (ack_seen) begin
            errors++;
            $display("FAIL reset_mid_noack: ack %0d exp 0", ack_seen);
        end
        do_txn(1'b1, 32'h8000_0040, 32'h0, 4'hF, 32'hFEED_FACE,
               0, 0, 0, 1'b0, 0, lat, err, a, wd, ds, rd, ml);
        exp_rdata = 32'hFEED_FACE;
        checks++;
        if (lat != 6 || err !== 1'b0 || RDATA !== exp_rdata) begin
            errors++;
            $display("FAIL reset_mid_after: lat %0d err %b rdata %h exp 6 0 %h",
                     lat, err, RDATA, exp_rdata);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_random();
        int lat; logic err, rd; logic [31:0] a, wd; logic [3:0] ds; bit ml;
        logic        rw;
        logic [31:0] addr, wdata, rdat;
        logic [3:0]  be;
        int          w, mode, d, r;
        for (int i = 0; i < 40; i++) begin
            rw    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
            rdat  = $urandom;
            be    = 4'($urandom_range(1, 15));
            w     = $urandom_range(0, 3);
            r     = $urandom_range(0, 9);
            mode  = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            d     = $urandom_range(0, 4);
            if (mode == 0 && $urandom_range(0, 5) == 0)
                d = $urandom_range(59, 62);
            do_txn(rw, addr, wdata, be, rdat, w, mode, d, 1'b0, 0,
                   lat, err, a, wd, ds, rd, ml);
            if (rw && !exp_error(mode, d)) exp_rdata = rdat;
            checks++;
            if (lat != exp_latency(w, mode, d) || err !== exp_error(mode, d)) begin
                errors++;
                $display("FAIL rnd%0d_term: lat %0d err %b exp %0d %b (mode %0d d %0d w %0d)",
                         i, lat, err, exp_latency(w, mode, d),
                         exp_error(mode, d), mode, d, w);
            end
            checks++;
            if (RDATA !== exp_rdata) begin
                errors++;
                $display("FAIL rnd%0d_rdata: got %h exp %h", i, RDATA, exp_rdata);
            end
            checks++;
            if (a !== {addr[31:2], 2'b00} || rd !== rw || ds !== ~be) begin
                errors++;
                $display("FAIL rnd%0d_bus: addr %h rd %b ds %b exp %h %b %b",
                         i, a, rd, ds, {addr[31:2], 2'b00}, rw, ~be);
            end
            if (!rw) begin
                checks++;
                if (wd !== wdata) begin
                    errors++;
                    $display("FAIL rnd%0d_wdata: got %h exp %h", i, wd, wdata);
                end
            end
            repeat (3) @(negedge CLK);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write();
        test_timeout();
        test_berr_dtack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
